// File: rtl/ysyx_24090003_imem_rd.sv
// Instruction-memory read master: takes one fetch PC from the IFU, does a single-beat
// AXI4-Lite read, and hands back instruction/PC/fault, honouring redirect flushes.
module ysyx_24090003_imem_rd (
   input  logic        cpu_clk,
   input  logic        cpu_rs_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_pc,
   input  logic        flush,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_inst,
   output logic [31:0] rsp_pc,
   output logic        rsp_fault,
   output logic [31:0] araddr,
   output logic        arvalid,
   input  logic        arready,
   input  logic [31:0] rdata,
   input  logic [1:0]  rresp,
   input  logic        rvalid,
   output logic        rready,
   output logic [31:0] fetch_cnt
);

   localparam logic [31:0] FAULT_INST = 32'h00100073;

   typedef enum logic [1:0] {
      IDLE,
      ADDR,
      DATA,
      RESP
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] inst_q, inst_d;
   logic [31:0] rsppc_q, rsppc_d;
   logic [31:0] cnt_q, cnt_d;
   logic        fault_q, fault_d;
   logic        drop_q, drop_d;

   always_ff @(posedge cpu_clk or negedge cpu_rs_n) begin
      if (!cpu_rs_n) begin
         state_q <= IDLE;
         pc_q    <= 32'h0;
         inst_q  <= 32'h0;
         rsppc_q <= 32'h0;
         cnt_q   <= 32'h0;
         fault_q <= 1'b0;
         drop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         inst_q  <= inst_d;
         rsppc_q <= rsppc_d;
         cnt_q   <= cnt_d;
         fault_q <= fault_d;
         drop_q  <= drop_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      inst_d  = inst_q;
      rsppc_d = rsppc_q;
      cnt_d   = cnt_q;
      fault_d = fault_q;
      drop_d  = drop_q;
      unique case (state_q)
         IDLE: begin
            if (req_valid && !flush) begin
               pc_d = req_pc;
               if (req_pc[1:0] != 2'b00) begin
                  inst_d  = FAULT_INST;
                  fault_d = 1'b1;
                  rsppc_d = req_pc;
                  state_d = RESP;
               end else begin
                  state_d = ADDR;
               end
            end
         end
         // The address cannot be withdrawn once offered, so a flush only marks the beat for discard.
         ADDR: begin
            if (flush) drop_d = 1'b1;
            if (arready) state_d = DATA;
         end
         DATA: begin
            if (rvalid) begin
               if (drop_q || flush) begin
                  drop_d  = 1'b0;
                  state_d = IDLE;
               end else begin
                  inst_d  = (rresp != 2'b00) ? FAULT_INST : rdata;
                  fault_d = (rresp != 2'b00);
                  rsppc_d = pc_q;
                  state_d = RESP;
               end
            end else if (flush) begin
               drop_d = 1'b1;
            end
         end
         RESP: begin
            if (flush) begin
               state_d = IDLE;
            end else if (rsp_ready) begin
               cnt_d   = cnt_q + 32'h1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign req_ready = (state_q == IDLE);
   assign arvalid   = (state_q == ADDR);
   assign rready    = (state_q == DATA);
   assign rsp_valid = (state_q == RESP);
   assign araddr    = pc_q;
   assign rsp_inst  = inst_q;
   assign rsp_pc    = rsppc_q;
   assign rsp_fault = fault_q;
   assign fetch_cnt = cnt_q;

endmodule

// File: tb/tb_ysyx_24090003_imem_rd.sv
// Bench for ysyx_24090003_imem_rd: a behavioural AXI4-Lite memory slave, a fetch-level
// reference model, directed vector table, flush/reset sequences and a random phase.
module tb_ysyx_24090003_imem_rd;

   localparam logic [31:0] FAULT_INST = 32'h00100073;

   logic        cpu_clk   = 1'b0;
   logic        cpu_rs_n  = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [31:0] req_pc    = 32'h0;
   logic        flush     = 1'b0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_inst;
   logic [31:0] rsp_pc;
   logic        rsp_fault;
   logic [31:0] araddr;
   logic        arvalid;
   logic        arready   = 1'b0;
   logic [31:0] rdata     = 32'h0;
   logic [1:0]  rresp     = 2'b00;
   logic        rvalid    = 1'b0;
   logic        rready;
   logic [31:0] fetch_cnt;

   ysyx_24090003_imem_rd dut (
      .cpu_clk   (cpu_clk),
      .cpu_rs_n  (cpu_rs_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_pc    (req_pc),
      .flush     (flush),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_inst  (rsp_inst),
      .rsp_pc    (rsp_pc),
      .rsp_fault (rsp_fault),
      .araddr    (araddr),
      .arvalid   (arvalid),
      .arready   (arready),
      .rdata     (rdata),
      .rresp     (rresp),
      .rvalid    (rvalid),
      .rready    (rready),
      .fetch_cnt (fetch_cnt)
   );

   always #5 cpu_clk = ~cpu_clk;

   int checks = 0;
   int errors = 0;

   // Memory slave configuration and state
   int          arWaitCfg = 0;
   int          rWaitCfg  = 0;
   logic [1:0]  rrespCfg  = 2'b00;
   int          arCnt     = 0;
   int          rCnt      = 0;
   bit          rPend     = 1'b0;
   logic [31:0] rAddr     = 32'h0;
   logic [1:0]  rRespCur  = 2'b00;
   int          arHs      = 0;
   int          rHs       = 0;

   // Fetch-level reference model
   bit          pAct      = 1'b0;
   bit          pKilled   = 1'b0;
   logic [31:0] pPc       = 32'h0;
   logic [31:0] pInst     = 32'h0;
   logic        pFault    = 1'b0;
   logic [31:0] modelCnt  = 32'h0;
   int          delivered = 0;
   bit          lastAccept = 1'b0;

   // Previous-cycle protocol state for stability checks
   bit          prevArWait  = 1'b0;
   bit          prevRWait   = 1'b0;
   bit          prevRspHold = 1'b0;
   logic [31:0] prevAraddr  = 32'h0;
   logic [31:0] prevInst    = 32'h0;
   logic [31:0] prevPc      = 32'h0;
   logic        prevFault   = 1'b0;

   typedef struct {
      logic [31:0] pc;
      int          aw;
      int          rw;
      logic [1:0]  resp;
      int          stall;
      logic [31:0] expInst;
      logic        expFault;
      int          expLat;
      int          expAr;
   } vec_t;

   vec_t vecs[8];
   vec_t afterFlush;

   function automatic logic [31:0] memWord(input logic [31:0] a);
      if (a == 32'h8000_0000) return 32'h0000_0413;
      if (a == 32'h8000_0008) return 32'hDEAD_BEEF;
      return a ^ 32'h5A5A_5A5A;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic checkFlag(input string name, input logic cond);
      checks++;
      if (cond !== 1'b1) begin
         errors++;
         $display("[TB] FAIL %s: condition got %b expected 1", name, cond);
      end
   endtask

   task automatic setSlave(input int aw, input int rw, input logic [1:0] resp);
      arWaitCfg = aw;
      rWaitCfg  = rw;
      rrespCfg  = resp;
      arCnt     = aw;
   endtask

   task automatic clearModel();
      pAct        = 1'b0;
      pKilled     = 1'b0;
      modelCnt    = 32'h0;
      delivered   = 0;
      prevArWait  = 1'b0;
      prevRWait   = 1'b0;
      prevRspHold = 1'b0;
      rPend       = 1'b0;
      arCnt       = arWaitCfg;
   endtask

   // Runs once per cycle just before the active edge, with inputs and outputs settled.
   task automatic observe();
      lastAccept = 1'b0;
      if (!cpu_rs_n) return;
      checkOutput("fetchCnt", fetch_cnt, modelCnt);
      if (prevArWait) begin
         checkFlag("arvalidHeld", arvalid);
         checkOutput("araddrStable", araddr, prevAraddr);
      end
      if (prevRWait) checkFlag("rreadyHeld", rready);
      if (prevRspHold) begin
         checkFlag("rspValidHeld", rsp_valid);
         checkOutput("rspInstStable", rsp_inst, prevInst);
         checkOutput("rspPcStable", rsp_pc, prevPc);
         checkOutput("rspFaultStable", {31'h0, rsp_fault}, {31'h0, prevFault});
      end
      checkFlag("rspOwner", !rsp_valid || (pAct && !pKilled));
      checkFlag("reqReadyBusy", !(req_ready && pAct && !pKilled));
      checkFlag("reqReadyFree", pAct || req_ready);
      checkFlag("noArMisaligned", !(arvalid && pAct && (pPc[1:0] != 2'b00)));
      if (arvalid && pAct && !pKilled) checkOutput("araddrPc", araddr, pPc);

      if (rsp_valid && rsp_ready && !flush) begin
         checkOutput("modelInst", rsp_inst, pInst);
         checkOutput("modelPc", rsp_pc, pPc);
         checkOutput("modelFault", {31'h0, rsp_fault}, {31'h0, pFault});
         modelCnt = modelCnt + 32'h1;
         delivered++;
         pAct = 1'b0;
      end else if (pAct && flush) begin
         pKilled = 1'b1;
      end

      if (req_valid && req_ready && !flush) begin
         lastAccept = 1'b1;
         pAct       = 1'b1;
         pKilled    = 1'b0;
         pPc        = req_pc;
         if (req_pc[1:0] != 2'b00 || rrespCfg != 2'b00) begin
            pInst  = FAULT_INST;
            pFault = 1'b1;
         end else begin
            pInst  = memWord(req_pc);
            pFault = 1'b0;
         end
      end

      prevArWait  = arvalid && !arready;
      prevRWait   = rready && !rvalid;
      prevRspHold = rsp_valid && !rsp_ready && !flush;
      prevAraddr  = araddr;
      prevInst    = rsp_inst;
      prevPc      = rsp_pc;
      prevFault   = rsp_fault;
   endtask

   // One clock cycle: drive slave outputs, observe, take the edge, advance the slave.
   task automatic tick();
      logic        arHsNow, rHsNow, arvS;
      bit          rPendS;
      logic [31:0] araddrS;
      arready = arvalid && !rPend && (arCnt == 0);
      rvalid  = rPend && (rCnt == 0);
      rdata   = rvalid ? memWord(rAddr) : 32'h0;
      rresp   = rvalid ? rRespCur : 2'b00;
      #1;
      observe();
      arHsNow = arvalid && arready;
      rHsNow  = rvalid && rready;
      arvS    = arvalid;
      rPendS  = rPend;
      araddrS = araddr;
      @(posedge cpu_clk);
      if (rHsNow) begin
         rPend = 1'b0;
         rHs++;
      end else if (rPendS && rCnt > 0) begin
         rCnt--;
      end
      if (arHsNow) begin
         rPend    = 1'b1;
         rAddr    = araddrS;
         rCnt     = rWaitCfg;
         rRespCur = rrespCfg;
         arCnt    = arWaitCfg;
         arHs++;
      end else if (arvS && arCnt > 0) begin
         arCnt--;
      end
      @(negedge cpu_clk);
   endtask

   task automatic applyStimulus(input vec_t v);
      int cyc;
      int hs0;
      hs0 = arHs;
      setSlave(v.aw, v.rw, v.resp);
      req_pc    = v.pc;
      req_valid = 1'b1;
      rsp_ready = 1'b0;
      tick();
      checkFlag("accepted", lastAccept);
      req_valid = 1'b0;
      cyc = 1;
      if (v.pc[1:0] != 2'b00) checkFlag("noArvalidMisaligned", !arvalid);
      while (rsp_valid !== 1'b1 && cyc < 64) begin
         tick();
         cyc++;
      end
      checkOutput("latency", 32'(cyc), 32'(v.expLat));
      checkOutput("rspInst", rsp_inst, v.expInst);
      checkOutput("rspPc", rsp_pc, v.pc);
      checkOutput("rspFault", {31'h0, rsp_fault}, {31'h0, v.expFault});
      repeat (v.stall) tick();
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      checkFlag("reqReadyAfter", req_ready);
      checkOutput("vecFetchCnt", fetch_cnt, 32'(delivered));
      checkOutput("arHandshakes", 32'(arHs - hs0), 32'(v.expAr));
   endtask

   task automatic waitIdleNoRsp(input string name);
      int cyc;
      cyc = 0;
      while (req_ready !== 1'b1 && cyc < 64) begin
         checkFlag({name, "NoRsp"}, !rsp_valid);
         tick();
         cyc++;
      end
      checkFlag({name, "Idle"}, req_ready);
   endtask

   task automatic acceptOne(input logic [31:0] pc);
      req_pc    = pc;
      req_valid = 1'b1;
      tick();
      checkFlag("acceptOne", lastAccept);
      req_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int hs0, r0, cyc;
      vecs[0] = '{32'h8000_0000, 0, 0, 2'd0, 0, 32'h0000_0413, 1'b0, 3, 1};
      vecs[1] = '{32'h8000_0004, 3, 2, 2'd0, 4, 32'hDA5A_5A5E, 1'b0, 8, 1};
      vecs[2] = '{32'h8000_0010, 0, 0, 2'd2, 0, FAULT_INST,    1'b1, 3, 1};
      vecs[3] = '{32'h8000_0002, 0, 0, 2'd0, 0, FAULT_INST,    1'b1, 1, 0};
      vecs[4] = '{32'h8000_0001, 2, 2, 2'd0, 1, FAULT_INST,    1'b1, 1, 0};
      vecs[5] = '{32'h8000_000C, 1, 0, 2'd1, 0, FAULT_INST,    1'b1, 4, 1};
      vecs[6] = '{32'h0000_0020, 1, 1, 2'd0, 2, 32'h5A5A_5A7A, 1'b0, 5, 1};
      vecs[7] = '{32'h8000_0003, 0, 0, 2'd3, 0, FAULT_INST,    1'b1, 1, 0};
      afterFlush = '{32'h8000_0010, 0, 0, 2'd0, 0, 32'hDA5A_5A4A, 1'b0, 3, 1};

      // Reset values while reset is held
      #2;
      checkFlag("rstArvalid", !arvalid);
      checkFlag("rstRready", !rready);
      checkFlag("rstRspValid", !rsp_valid);
      checkFlag("rstRspFault", !rsp_fault);
      checkOutput("rstAraddr", araddr, 32'h0);
      checkOutput("rstRspInst", rsp_inst, 32'h0);
      checkOutput("rstRspPc", rsp_pc, 32'h0);
      checkOutput("rstFetchCnt", fetch_cnt, 32'h0);
      @(negedge cpu_clk);
      @(negedge cpu_clk);
      cpu_rs_n = 1'b1;
      #1;
      checkFlag("rstReqReady", req_ready);
      @(negedge cpu_clk);

      for (int i = 0; i < 8; i++) begin
         applyStimulus(vecs[i]);
         if (i == 0) checkOutput("firstFetchCnt", fetch_cnt, 32'h1);
      end

      // Request together with flush in IDLE is ignored
      req_pc    = 32'h8000_0040;
      req_valid = 1'b1;
      flush     = 1'b1;
      tick();
      flush     = 1'b0;
      req_valid = 1'b0;
      checkFlag("flushIdleIgnored", req_ready && !arvalid && !rsp_valid);

      // Flush in ADDR while arready is held low
      setSlave(3, 0, 2'd0);
      hs0 = arHs;
      r0  = rHs;
      acceptOne(32'h8000_0008);
      checkFlag("flushAddrArvalid", arvalid);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      checkFlag("arvalidKeptAfterFlush", arvalid);
      waitIdleNoRsp("flushAddr");
      checkOutput("flushAddrArHs", 32'(arHs - hs0), 32'h1);
      checkOutput("flushAddrRBeat", 32'(rHs - r0), 32'h1);
      applyStimulus(afterFlush);

      // Flush in DATA before rvalid
      setSlave(0, 3, 2'd0);
      r0 = rHs;
      acceptOne(32'h8000_0020);
      tick();
      checkFlag("flushDataRready", rready);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      waitIdleNoRsp("flushData");
      checkOutput("flushDataRBeat", 32'(rHs - r0), 32'h1);

      // Flush in RESP drops the response even with rsp_ready high
      setSlave(0, 0, 2'd0);
      acceptOne(32'h8000_0024);
      cyc = 0;
      while (rsp_valid !== 1'b1 && cyc < 64) begin
         tick();
         cyc++;
      end
      checkFlag("flushRespReached", rsp_valid);
      flush     = 1'b1;
      rsp_ready = 1'b1;
      tick();
      flush     = 1'b0;
      rsp_ready = 1'b0;
      checkFlag("flushRespGone", !rsp_valid && req_ready);
      checkOutput("flushRespCnt", fetch_cnt, 32'(delivered));

      // Reset in the middle of DATA
      setSlave(0, 3, 2'd0);
      acceptOne(32'h8000_0028);
      tick();
      checkFlag("preResetRready", rready);
      #2;
      cpu_rs_n = 1'b0;
      #1;
      checkFlag("asyncRstArvalid", !arvalid);
      checkFlag("asyncRstRready", !rready);
      checkFlag("asyncRstRspValid", !rsp_valid);
      checkOutput("asyncRstFetchCnt", fetch_cnt, 32'h0);
      clearModel();
      @(negedge cpu_clk);
      cpu_rs_n = 1'b1;
      #1;
      checkFlag("postRstReqReady", req_ready);
      @(negedge cpu_clk);
      applyStimulus(vecs[0]);

      // Random phase against the reference model
      for (int n = 0; n < 600; n++) begin
         if (!req_valid && (!pAct || pKilled) && $urandom_range(0, 2) == 0) begin
            req_pc = 32'h8000_0000 + 32'($urandom_range(0, 255) << 2);
            if ($urandom_range(0, 7) == 0) req_pc[1:0] = 2'($urandom_range(1, 3));
            arWaitCfg = $urandom_range(0, 3);
            rWaitCfg  = $urandom_range(0, 3);
            rrespCfg  = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            req_valid = 1'b1;
         end
         flush     = ($urandom_range(0, 11) == 0);
         rsp_ready = ($urandom_range(0, 2) != 0);
         tick();
         if (lastAccept) req_valid = 1'b0;
      end
      req_valid = 1'b0;
      flush     = 1'b0;
      rsp_ready = 1'b1;
      cyc = 0;
      while (!(req_ready === 1'b1 && (!pAct || pKilled)) && cyc < 100) begin
         tick();
         cyc++;
      end
      checkFlag("drainIdle", req_ready && (!pAct || pKilled));
      checkOutput("finalFetchCnt", fetch_cnt, modelCnt);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ysyx_24090003_imem_rd.md
# ysyx_24090003_imem_rd

Instruction-memory read master sitting directly upstream of the IFU. It accepts a fetch PC from the IFU over a valid/ready handshake and issues a single-beat AXI4-Lite read (AR/R channels only). It returns the 32-bit instruction, its PC and a fault flag over a second valid/ready handshake. A flush from the execute/redirect logic discards any in-flight or held fetch without violating AXI channel rules.

## Interface
- FAULT_INST, 32'h00100073, instruction word returned on a bus error or misaligned PC (ebreak, so the simulator traps).
- cpu_clk  in  1  clock; all state updates on the rising edge.
- cpu_rs_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  IFU has a fetch PC.
- req_ready  out  1  block can accept a request.
- req_pc  in  32  fetch address.
- flush  in  1  discard the current fetch (redirect).
- rsp_valid  out  1  instruction available.
- rsp_ready  in  1  IFU consumes the response.
- rsp_inst  out  32  fetched instruction.
- rsp_pc  out  32  PC of rsp_inst.
- rsp_fault  out  1  rsp_inst is FAULT_INST because of misalignment or rresp != 0.
- araddr  out  32, arvalid  out  1, arready  in  1  AXI4-Lite read address channel.
- rdata  in  32, rresp  in  2, rvalid  in  1, rready  out  1  AXI4-Lite read data channel.
- fetch_cnt  out  32  count of responses delivered (rsp_valid && rsp_ready && !flush).

## Operation
- FSM states are IDLE, ADDR, DATA and RESP. Outputs are registered or decoded from state only; there is no combinational path from inputs to outputs.
- IDLE:
  - req_ready=1.
  - On req_valid && !flush, latch pc_q=req_pc.
  - If req_pc[1:0]!=0, go to RESP with rsp_inst=FAULT_INST and rsp_fault=1; no bus transaction is issued.
  - Otherwise go to ADDR.
  - req_valid && flush in the same cycle: the request is ignored.
- ADDR:
  - arvalid=1, araddr=pc_q.
  - On arready, go to DATA.
  - flush here sets drop=1. arvalid stays high until the handshake completes, because AXI forbids withdrawing the address.
- DATA:
  - rready=1.
  - On rvalid:
    - If drop || flush: go to IDLE, clear drop, discard the data.
    - Else: latch rsp_inst (rdata, or FAULT_INST if rresp!=0), set rsp_fault=(rresp!=0), latch rsp_pc=pc_q, go to RESP.
  - flush without rvalid sets drop=1.
- RESP:
  - rsp_valid=1.
  - On rsp_ready && !flush: go to IDLE and increment fetch_cnt.
  - On flush: go to IDLE and drop the response. The IFU must ignore a response in any cycle in which it asserts flush.
- req_ready=0 in every state except IDLE. Only one request is outstanding at a time.
- drop is only cleared on R completion or reset.
- fetch_cnt wraps from 32'hFFFFFFFF to 0.

## Timing
- Reset (cpu_rs_n=0, asynchronous, takes effect immediately):
  - State is IDLE.
  - arvalid=0, rready=0, rsp_valid=0, rsp_fault=0, drop=0.
  - araddr=0, rsp_inst=0, rsp_pc=0, fetch_cnt=0.
  - req_ready=1 after reset deasserts.
- Reset mid-transaction abandons the transaction. The memory slave is reset by the same signal.
- Minimum latency, aligned PC, arready and rvalid at the earliest opportunity:
  - Cycle 0: request accepted.
  - Cycle 1: arvalid high, handshake.
  - Cycle 2: rready high, rvalid.
  - Cycle 3: rsp_valid.
- Next request is accepted at the earliest in the cycle after the response handshake (IDLE).
- Misaligned PC: rsp_valid in cycle 1 after acceptance.
- Wait states:
  - arvalid and araddr stay stable while arready=0.
  - rready stays high until rvalid.
  - rsp_* stay stable while rsp_valid && !rsp_ready.
- Flush cost: a flush at any point before the R handshake costs exactly the remaining bus latency; no response is produced.

## Test plan
- Aligned fetch:
  - Stimulus: req_pc=0x80000000, memory returns 0x00000413 with zero wait states.
  - Required response: rsp_valid in cycle 3, rsp_inst=0x00000413, rsp_pc=0x80000000, rsp_fault=0, fetch_cnt=1.
- Wait states and backpressure:
  - Stimulus: arready low 3 cycles, rvalid 2 cycles after the AR handshake, rsp_ready low 4 cycles.
  - Required response: araddr, arvalid and rsp_* remain stable; exactly one AR handshake; fetch_cnt increments once.
- Flush in ADDR:
  - Stimulus: flush in ADDR while arready=0.
  - Required response: arvalid stays high until arready; the R beat (rdata=0xDEADBEEF) is consumed and discarded; no rsp_valid; the next req_pc=0x80000010 returns its own data.
- Bus error and misalignment:
  - Stimulus A: rresp=2'b10.
  - Required response A: rsp_inst=0x00100073, rsp_fault=1.
  - Stimulus B: req_pc=0x80000002.
  - Required response B: no arvalid; rsp_valid next cycle with fault=1 and rsp_pc=0x80000002.
- Reset mid-transaction:
  - Stimulus: cpu_rs_n low during DATA.
  - Required response: arvalid, rready and rsp_valid drop to 0 asynchronously; fetch_cnt=0; req_ready=1 after release; a subsequent fetch completes normally.
